// File: rtl/bcd_pkg.sv
// -----------------------------------------------------------------------------
// bcd_pkg
//   Shared types and helpers for the cascaded BCD tick divider.
//   - bcd_digit_t : one packed BCD digit (4 bits)
//   - BCD_NINE    : largest legal BCD digit value
//   - bcd_clamp() : saturates an out-of-range nibble (10..15) to 9
// -----------------------------------------------------------------------------
package bcd_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_NINE = 4'd9;

    function automatic bcd_digit_t bcd_clamp(input bcd_digit_t d);
        return (d > BCD_NINE) ? BCD_NINE : d;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// -----------------------------------------------------------------------------
// bcd_digit
//   One decade of the cascaded BCD counter.
//   Ports:
//     clk       in   system clock, rising edge
//     reset     in   synchronous active-high reset, highest priority
//     clr       in   synchronous clear to 0
//     en        in   advance enable (carry-in from the chain)
//     load_zero in   force the digit to 0 on the next edge (terminal count)
//     q         out  current digit value, always 0..9
//     is_nine   out  q == 9, feeds the carry chain of the next digit
// -----------------------------------------------------------------------------
module bcd_digit
    import bcd_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic       en,
    input  logic       load_zero,
    output logic [3:0] q,
    output logic       is_nine
);

    bcd_digit_t q_q;
    bcd_digit_t q_d;

    // NOTE: q_d gets its hold value first so every path assigns it; otherwise
    // the missing else-branch would infer a latch.
    always_comb begin
        q_d = q_q;
        if (clr || load_zero) begin
            q_d = '0;
        end else if (en) begin
            q_d = (q_q == BCD_NINE) ? bcd_digit_t'(0) : q_q + 4'd1;
        end
    end

    // NOTE: state registers use non-blocking assignment so every flop samples
    // pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk) begin
        if (reset) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q       = q_q;
    assign is_nine = (q_q == BCD_NINE);

endmodule

// File: rtl/bcd_tick_divider.sv
// -----------------------------------------------------------------------------
// bcd_tick_divider
//   N-digit cascaded BCD prescaler with a run-time programmable terminal count.
//   Divides clk by (TC+1): the count runs 0..TC, then returns to 0, and tick
//   pulses combinationally in the cycle where count == TC while enabled.
//   Optional feature macro: TICK_FLAG_EN adds a sticky tick flag.
//   Parameters:
//     NUM_DIGITS  number of BCD digits (1..8)
//   Ports:
//     clk       in   system clock, rising edge
//     reset     in   synchronous active-high reset, overrides clr and en
//     en        in   count enable
//     clr       in   synchronous clear of the count, overrides en
//     tc_value  in   BCD terminal count, digit i at [4i+3:4i]
//     flag_clr  in   (TICK_FLAG_EN only) clears tick_flag; set wins
//     count     out  current BCD count, same packing as tc_value
//     c_enable  out  per-digit advance enable, bit 0 = en & !clr
//     tick      out  one-cycle pulse at the terminal count
//     tick_flag out  (TICK_FLAG_EN only) sticky copy of tick
// -----------------------------------------------------------------------------
module bcd_tick_divider
    import bcd_pkg::*;
#(
    parameter int NUM_DIGITS = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    en,
    input  logic                    clr,
    input  logic [4*NUM_DIGITS-1:0] tc_value,
`ifdef TICK_FLAG_EN
    input  logic                    flag_clr,
    output logic                    tick_flag,
`endif
    output logic [4*NUM_DIGITS-1:0] count,
    output logic [NUM_DIGITS-1:0]   c_enable,
    output logic                    tick
);

    logic [NUM_DIGITS-1:0] dig_nine;
    logic [NUM_DIGITS-1:0] dig_match;
    logic [NUM_DIGITS-1:0] carry;
    logic                  run;
    logic                  tc_hit;
    logic                  all_nine;
    logic                  load_zero;

    // Reset is folded in so the enables and tick read 0 during a reset cycle.
    assign run = en & ~clr & ~reset;

    // Each carry is built from the enable and the lower digits directly,
    // which keeps the chain free of vector self-dependency.
    assign carry[0] = run;
    for (genvar i = 1; i < NUM_DIGITS; i++) begin : g_carry
        assign carry[i] = run & (&dig_nine[i-1:0]);
    end

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_match
        assign dig_match[i] = (count[4*i +: 4] == bcd_clamp(tc_value[4*i +: 4]));
    end

    assign tc_hit   = &dig_match;
    assign all_nine = &dig_nine;
    assign tick     = run & tc_hit;

    // Terminal count forces all digits to 0 regardless of the carry chain.
    // The all-nines term is the natural wrap, stated explicitly so the wrap
    // does not depend on every digit rolling over in the same edge.
    assign load_zero = tick | (run & all_nine);

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
        bcd_digit u_digit (
            .clk       (clk),
            .reset     (reset),
            .clr       (clr),
            .en        (carry[i]),
            .load_zero (load_zero),
            .q         (count[4*i +: 4]),
            .is_nine   (dig_nine[i])
        );
    end

    assign c_enable = carry;

`ifdef TICK_FLAG_EN
    logic flag_q;
    logic flag_d;

    // Set is applied last so a tick in the same cycle as flag_clr wins.
    always_comb begin
        flag_d = flag_q;
        if (flag_clr) flag_d = 1'b0;
        if (tick)     flag_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            flag_q <= 1'b0;
        end else begin
            flag_q <= flag_d;
        end
    end

    assign tick_flag = flag_q;
`endif

endmodule
